// File: rtl/lfsr_session_arbiter.sv
// Round-robin arbiter that lends one 4-bit LFSR scrambler to NREQ clients:
// load seed, run RUN_CYCLES steps, shift the result out LSB first, pulse done.
module lfsr_session_arbiter #(
   parameter int NREQ       = 4,
   parameter int RUN_CYCLES = 8
) (
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic [NREQ-1:0]     req_i,
   input  logic [4*NREQ-1:0]   seed_bus_i,
   output logic [NREQ-1:0]     gnt_o,
   output logic                busy_o,
   output logic                out_bit_o,
   output logic                out_valid_o,
   output logic                done_o
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic [2:0] {IDLE, RUN, SHIFT, DONE, FINISH} state_t;

   state_t          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            busy_q, busy_d;
   logic            outBit_q, outBit_d;
   logic            outValid_q, outValid_d;
   logic            done_q, done_d;
   logic [3:0]      lfsr_q, lfsr_d;
   logic [3:0]      count_q, count_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   win_q, win_d;

   logic            winValid;
   logic [IW-1:0]   winIdx;
   logic [3:0]      seedSel;

   // Scanning from the highest offset down leaves the nearest requester
   // at or above the pointer as the final winner.
   always_comb begin
      winValid = 1'b0;
      winIdx   = '0;
      for (int off = NREQ - 1; off >= 0; off--) begin
         if (req_i[(int'(ptr_q) + off) % NREQ]) begin
            winValid = 1'b1;
            winIdx   = IW'((int'(ptr_q) + off) % NREQ);
         end
      end
      seedSel = seed_bus_i[4*winIdx +: 4];
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      busy_d     = busy_q;
      outBit_d   = outBit_q;
      outValid_d = outValid_q;
      done_d     = done_q;
      lfsr_d     = lfsr_q;
      count_d    = count_q + 4'd1;
      ptr_d      = ptr_q;
      win_d      = win_q;
      case (state_q)
         IDLE: begin
            count_d = '0;
            if (winValid) begin
               gnt_d   = NREQ'(1) << winIdx;
               lfsr_d  = (seedSel == 4'b0000) ? 4'b0001 : seedSel;
               busy_d  = 1'b1;
               win_d   = winIdx;
               state_d = RUN;
            end
         end
         RUN: begin
            lfsr_d = {lfsr_q[3] ^ lfsr_q[1] ^ lfsr_q[0], lfsr_q[3:1]};
            if (count_q == 4'(RUN_CYCLES - 1)) begin
               state_d = SHIFT;
               count_d = '0;
            end
         end
         SHIFT: begin
            lfsr_d     = {1'b0, lfsr_q[3:1]};
            outBit_d   = lfsr_q[0];
            outValid_d = 1'b1;
            if (count_q == 4'd3) begin
               state_d = DONE;
               count_d = '0;
            end
         end
         DONE: begin
            outValid_d = 1'b0;
            done_d     = 1'b1;
            state_d    = FINISH;
            count_d    = '0;
         end
         FINISH: begin
            // Grant drops here; the next arbitration waits one IDLE cycle.
            gnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            ptr_d   = IW'((int'(win_q) + 1) % NREQ);
            state_d = IDLE;
            count_d = '0;
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         busy_q     <= 1'b0;
         outBit_q   <= 1'b0;
         outValid_q <= 1'b0;
         done_q     <= 1'b0;
         lfsr_q     <= '0;
         count_q    <= '0;
         ptr_q      <= '0;
         win_q      <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         busy_q     <= busy_d;
         outBit_q   <= outBit_d;
         outValid_q <= outValid_d;
         done_q     <= done_d;
         lfsr_q     <= lfsr_d;
         count_q    <= count_d;
         ptr_q      <= ptr_d;
         win_q      <= win_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign busy_o      = busy_q;
   assign out_bit_o   = outBit_q;
   assign out_valid_o = outValid_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_lfsr_session_arbiter.sv
// Scoreboard bench for lfsr_session_arbiter: stimulus pushes hand-computed
// grant/bit/done events; a negedge monitor pops and compares them.
module tb_lfsr_session_arbiter;

   localparam int NREQ = 4;
   localparam int KGRANT = 0;
   localparam int KBIT   = 1;
   localparam int KDONE  = 2;

   logic             clock;
   logic             reset;
   logic [NREQ-1:0]  req;
   logic [4*NREQ-1:0] seedBus;
   logic [NREQ-1:0]  gnt;
   logic             busy;
   logic             outBit;
   logic             outValid;
   logic             done;

   typedef struct {
      int         kind;
      logic [3:0] val;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   grantCount = 0;
   int   gntLen = 0;
   int   lastRise = 0;
   bit   havePrevRise = 0;
   bit   checkPeriod = 0;
   logic [NREQ-1:0] prevGnt = '0;

   lfsr_session_arbiter #(.NREQ(NREQ), .RUN_CYCLES(8)) dut (
      .clock_i     (clock),
      .reset_i     (reset),
      .req_i       (req),
      .seed_bus_i  (seedBus),
      .gnt_o       (gnt),
      .busy_o      (busy),
      .out_bit_o   (outBit),
      .out_valid_o (outValid),
      .done_o      (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic pushSession(input logic [3:0] g, input logic [3:0] result);
      expQ.push_back('{KGRANT, g});
      for (int i = 0; i < 4; i++) expQ.push_back('{KBIT, {3'b000, result[i]}});
      expQ.push_back('{KDONE, g});
   endtask

   task automatic popExpect(input int kind, input logic [3:0] actual, input string name);
      exp_t e;
      checks++;
      if (expQ.size() == 0) begin
         errors++;
         $display("[TB] FAIL %s: unexpected event, got %0h, expected none", name, actual);
      end else begin
         e = expQ.pop_front();
         if (e.kind != kind || e.val !== actual) begin
            errors++;
            $display("[TB] FAIL %s: got kind %0d value %0h, expected kind %0d value %0h (t=%0t)",
                     name, kind, actual, e.kind, e.val, $time);
         end
      end
   endtask

   // Monitor: event scoreboard plus per-cycle structural checks.
   always @(negedge clock) begin
      cyc++;
      if (reset) begin
         prevGnt = '0;
         gntLen  = 0;
      end else begin
         checkOutput("onehot_gnt", 8'($onehot0(gnt)), 8'd1);
         checkOutput("valid_done_overlap", 8'(outValid & done), 8'd0);
         if (gnt != '0 && prevGnt == '0) begin
            grantCount++;
            popExpect(KGRANT, gnt, "grant");
            if (checkPeriod && havePrevRise) checkOutput("grant_period", 8'(cyc - lastRise), 8'd15);
            lastRise     = cyc;
            havePrevRise = 1'b1;
         end
         if (gnt != '0) gntLen++;
         if (gnt == '0 && prevGnt != '0) begin
            checkOutput("gnt_length", 8'(gntLen), 8'd14);
            gntLen = 0;
         end
         if (outValid) popExpect(KBIT, {3'b000, outBit}, "out_bit");
         if (done) popExpect(KDONE, gnt, "done_gnt");
         prevGnt = gnt;
      end
   end

   task automatic applyStimulus(input logic [3:0] r, input logic [15:0] seeds);
      req     = r;
      seedBus = seeds;
   endtask

   task automatic waitGnt(input logic [3:0] g);
      int n = 0;
      while (gnt !== g && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (gnt !== g) checkOutput("wait_gnt_timeout", 8'(gnt), 8'(g));
   endtask

   task automatic waitGrants(input int target);
      int n = 0;
      while (grantCount < target && n < 400) begin
         @(negedge clock);
         n++;
      end
      if (grantCount < target) checkOutput("wait_grants_timeout", 8'(grantCount), 8'(target));
   endtask

   task automatic waitValid(input int count);
      int seen = 0;
      int n = 0;
      while (seen < count && n < 200) begin
         @(negedge clock);
         if (outValid) seen++;
         n++;
      end
      if (seen < count) checkOutput("wait_valid_timeout", 8'(seen), 8'(count));
   endtask

   task automatic waitIdle();
      int n = 0;
      @(negedge clock);
      while ((busy || expQ.size() != 0) && n < 400) begin
         @(negedge clock);
         n++;
      end
      checkOutput("idle_queue_empty", 8'(expQ.size()), 8'd0);
      expQ.delete();
   endtask

   task automatic doReset();
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      checkOutput("reset_outputs", {gnt, busy, outBit, outValid, done}, 8'd0);
      reset = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      req     = '0;
      seedBus = '0;
      doReset();

      // Single request, seed 1000 -> 1110 after 8 steps.
      pushSession(4'b0001, 4'b1110);
      applyStimulus(4'b0001, 16'h0008);
      waitGnt(4'b0001);
      req = '0;
      waitIdle();

      // Pointer now 1: requester 1 wins over 0, then 0 follows.
      pushSession(4'b0010, 4'b1100);
      pushSession(4'b0001, 4'b1110);
      applyStimulus(4'b0011, 16'h0018);
      waitGnt(4'b0010);
      req = 4'b0001;
      waitGnt(4'b0001);
      req = '0;
      waitIdle();

      // Zero seed is replaced by 0001 -> 1100.
      pushSession(4'b0100, 4'b1100);
      applyStimulus(4'b0100, 16'h0000);
      waitGnt(4'b0100);
      req = '0;
      waitIdle();

      // Pointer at 3: requester 3 (0011 -> 1000) before requester 0.
      pushSession(4'b1000, 4'b1000);
      pushSession(4'b0001, 4'b1110);
      applyStimulus(4'b1001, 16'h3008);
      waitGnt(4'b1000);
      waitGnt(4'b0001);
      req = '0;
      waitIdle();

      // Drop req and corrupt seed mid-RUN: 1100 -> 0111 still delivered.
      pushSession(4'b0010, 4'b0111);
      applyStimulus(4'b0010, 16'h00C0);
      waitGnt(4'b0010);
      repeat (3) @(negedge clock);
      applyStimulus(4'b0000, 16'h0000);
      waitIdle();

      // Reset after two shifted bits of requester 2 (0111 -> 0001).
      expQ.push_back('{KGRANT, 4'b0100});
      expQ.push_back('{KBIT, 4'd1});
      expQ.push_back('{KBIT, 4'd0});
      applyStimulus(4'b0100, 16'h0700);
      waitGnt(4'b0100);
      waitValid(2);
      #1 reset = 1'b1;
      #1 checkOutput("midsession_reset", {gnt, busy, outBit, outValid, done}, 8'd0);
      checkOutput("midsession_queue", 8'(expQ.size()), 8'd0);
      req = '0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      pushSession(4'b0010, 4'b1100);
      applyStimulus(4'b1010, 16'h3010);
      waitGnt(4'b0010);
      req = '0;
      waitIdle();

      // All four requesting from reset: strict rotation with 15-cycle period.
      applyStimulus(4'b1111, 16'h3718);
      doReset();
      checkPeriod  = 1'b1;
      havePrevRise = 1'b0;
      pushSession(4'b0001, 4'b1110);
      pushSession(4'b0010, 4'b1100);
      pushSession(4'b0100, 4'b0001);
      pushSession(4'b1000, 4'b1000);
      pushSession(4'b0001, 4'b1110);
      waitGrants(grantCount + 5);
      req = '0;
      waitIdle();
      checkPeriod = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/lfsr_session_arbiter.md
# lfsr_session_arbiter

Shares a single 4-bit LFSR scrambler datapath among NREQ requesters. Each session is granted round-robin. In a session the block:
- loads the winner's seed;
- runs the LFSR for RUN_CYCLES steps;
- shifts the 4-bit result out serially to the winner;
- signals completion.

It sits between the pattern-consuming clients and the scrambler. It owns the LFSR register, so no client drives the scrambler directly.

## Interface
- NREQ, 4: number of requesters (2..8).
- RUN_CYCLES, 8: LFSR steps per session (1..15).
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req  in  NREQ  per-requester session request, level.
- seed_bus  in  4*NREQ  seed for requester i at bits [4i+3:4i].
- gnt  out  NREQ  one-hot grant, held for the whole session.
- busy  out  1  high whenever state != IDLE.
- out_bit  out  1  serial result bit, LSB first.
- out_valid  out  1  qualifies out_bit.
- done  out  1  one-cycle pulse at session end, coincident with gnt.

## Operation
- All outputs registered; reset values: gnt=0, busy=0, out_bit=0, out_valid=0, done=0, state=IDLE, lfsr=0, count=0, rr pointer=0.
- LFSR step: lfsr[2:0] <= lfsr[3:1]; lfsr[3] <= lfsr[3]^lfsr[1]^lfsr[0].
- Shift step: lfsr <= {1'b0, lfsr[3:1]}; out_bit <= lfsr[0].
- Counter: 4-bit, cleared on every state change.
- Arbitration, evaluated only in IDLE:
  - winner = first i with req[i]=1, searching from the rr pointer upward with wrap;
  - after a session, the pointer becomes (winner+1) mod NREQ;
  - the pointer is unchanged if no req.
- Seed 4'b0000 is substituted with 4'b0001 at load (avoids lock-up).

State machine:
- IDLE: if |req, then gnt <= onehot(winner), lfsr <= seed (after substitution), busy <= 1 -> RUN. Else stay.
- RUN: LFSR step each cycle; count 0..RUN_CYCLES-1; on count==RUN_CYCLES-1 -> SHIFT.
- SHIFT: shift step each cycle, out_valid <= 1; 4 cycles; on the 4th -> DONE.
- DONE: out_valid <= 0, done <= 1 for one cycle; next edge -> IDLE with gnt <= 0, busy <= 0, done <= 0, pointer updated.

Boundary conditions:
- Deassertion of req by the granted requester mid-session is ignored; the session completes.
- Changes to seed_bus after load are ignored.
- Simultaneous requests: only the round-robin winner is granted; losers keep waiting, with no starvation (each waits at most NREQ-1 sessions).
- A requester holding req through DONE is re-arbitrated in the following IDLE cycle, behind any other pending requester.
- Reset asserted mid-session: immediate return to reset values; no done pulse; pointer back to 0.

## Timing
- req sampled high at edge k (IDLE): gnt and busy high after edge k.
- LFSR steps occur at edges k+1..k+RUN_CYCLES.
- out_valid high after edges k+RUN_CYCLES+1 .. k+RUN_CYCLES+4 (4 consecutive cycles, bits LSB first).
- done high after edge k+RUN_CYCLES+5.
- gnt, busy and done low after edge k+RUN_CYCLES+6.
- Earliest next grant: edge k+RUN_CYCLES+7 (one IDLE cycle between sessions).
- Defaults: gnt held 14 cycles; session-to-session period 15 cycles.
- out_valid never overlaps done; gnt is never more than one-hot.

## Test plan
- Single request, req=4'b0001, seed0=4'b1000, RUN_CYCLES=8 -> gnt=0001 for 14 cycles; out_bit sequence 0,1,1,1 with out_valid 4 cycles; one done pulse; pointer=1.
- Zero seed, req[2] only, seed2=4'b0000 -> substituted 0001; out_bit sequence 0,0,1,1; gnt=0100.
- All four requesting continuously from reset -> grants in order 0001, 0010, 0100, 1000, 0001, each 14 cycles with 1-cycle IDLE gap; no requester granted twice before all served.
- Pointer wrap with requests {0,3}, after a session for requester 2 -> requester 3 granted first, then requester 0.
- Requester drops req and changes seed during RUN -> session output unchanged from the captured seed; done still pulses.
- Reset asserted during SHIFT after 2 bits -> all outputs 0 immediately, no done; next session after reset is granted from pointer 0.
